// File: rtl/fb_draw_scheduler.sv
// fb_draw_scheduler: frame-buffer write scheduler for the 160x120 12-bit path.
// Each frame clears the buffer to BG_COLOR (one pixel per cycle). It then
// round-robins the single write port between two drawing clients until both
// report done, and idles until the next frame start.
// Optional build macro FB_SCHED_VSYNC_EN: frames start on the synchronised
// rising edge of the vsync port instead of the internal FRAME_CYCLES timebase.
module fb_draw_scheduler #(
   parameter int          W            = 160,
   parameter int          H            = 120,
   parameter int          FRAME_CYCLES = 10000000,
   parameter logic [11:0] BG_COLOR     = 12'h000
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef FB_SCHED_VSYNC_EN
   input  logic        vsync,
`endif
   input  logic [1:0]  req,
   input  logic [7:0]  req_x0,
   input  logic [7:0]  req_x1,
   input  logic [7:0]  req_y0,
   input  logic [7:0]  req_y1,
   input  logic [11:0] req_color0,
   input  logic [11:0] req_color1,
   input  logic [1:0]  done,
   output logic [1:0]  ack,
   output logic        wr_en,
   output logic [7:0]  CounterX,
   output logic [7:0]  CounterY,
   output logic [11:0] color,
   output logic [1:0]  phase,
   output logic        frame_start
);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_DRAW  = 2'b01,
      ST_WAIT  = 2'b10
   } state_t;

   localparam logic [7:0] X_LAST = 8'(W - 1);
   localparam logic [7:0] Y_LAST = 8'(H - 1);
   localparam logic [8:0] W_LIM  = 9'(W);
   localparam logic [8:0] H_LIM  = 9'(H);

   state_t      r_state;
   logic [7:0]  r_cx;
   logic [7:0]  r_cy;
   logic [1:0]  r_done;
   logic        r_rr;          // 1: client 1 wins the next contended cycle
   logic        r_wr_en;
   logic [7:0]  r_x;
   logic [7:0]  r_y;
   logic [11:0] r_color;
   logic        r_frame_start;

   logic        w_frame_start;
   logic [1:0]  w_gnt;
   logic [7:0]  w_sel_x;
   logic [7:0]  w_sel_y;
   logic [11:0] w_sel_color;
   logic        w_in_range;
   logic        w_done_all;

`ifdef FB_SCHED_VSYNC_EN
   logic r_vs_meta;
   logic r_vs_sync;
   logic r_vs_prev;

   // Two-flop synchroniser for vsync plus a delay flop for rising-edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vs_meta <= 1'b0;
         r_vs_sync <= 1'b0;
         r_vs_prev <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so each flop samples its pre-edge input.
         r_vs_meta <= vsync;
         r_vs_sync <= r_vs_meta;
         r_vs_prev <= r_vs_sync;
      end
   end

   assign w_frame_start = r_vs_sync & ~r_vs_prev;
`else
   localparam int             CW       = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(FRAME_CYCLES - 1);

   logic [CW-1:0] r_frame_cnt;

   // Free-running frame timebase; wraps to 0 on the frame-start cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_cnt <= '0;
      end else if (w_frame_start) begin
         r_frame_cnt <= '0;
      end else begin
         r_frame_cnt <= r_frame_cnt + CW'(1);
      end
   end

   assign w_frame_start = (r_frame_cnt == CNT_LAST);
`endif

   // Round-robin grant: only in DRAW, and never on a frame-start cycle
   always_comb begin
      // NOTE: default assignment first so no latch is inferred on any path.
      w_gnt = 2'b00;
      if ((r_state == ST_DRAW) && !w_frame_start) begin
         case (req)
            2'b01:   w_gnt = 2'b01;
            2'b10:   w_gnt = 2'b10;
            2'b11:   w_gnt = r_rr ? 2'b10 : 2'b01;
            default: w_gnt = 2'b00;
         endcase
      end
   end

   assign ack         = w_gnt;
   assign w_sel_x     = w_gnt[1] ? req_x1     : req_x0;
   assign w_sel_y     = w_gnt[1] ? req_y1     : req_y0;
   assign w_sel_color = w_gnt[1] ? req_color1 : req_color0;
   assign w_in_range  = ({1'b0, w_sel_x} < W_LIM) && ({1'b0, w_sel_y} < H_LIM);
   assign w_done_all  = &(r_done | done);

   // Scheduler FSM with registered write port; frame start overrides every state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_CLEAR;
         r_cx          <= 8'd0;
         r_cy          <= 8'd0;
         r_done        <= 2'b00;
         r_rr          <= 1'b0;
         r_wr_en       <= 1'b0;
         r_x           <= 8'd0;
         r_y           <= 8'd0;
         r_color       <= 12'd0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_start;
         r_wr_en       <= 1'b0;
         if (w_frame_start) begin
            r_state <= ST_CLEAR;
            r_cx    <= 8'd0;
            r_cy    <= 8'd0;
            r_done  <= 2'b00;
         end else begin
            case (r_state)
               ST_CLEAR: begin
                  r_wr_en <= 1'b1;
                  r_x     <= r_cx;
                  r_y     <= r_cy;
                  r_color <= BG_COLOR;
                  if (r_cx == X_LAST) begin
                     r_cx <= 8'd0;
                     if (r_cy == Y_LAST) begin
                        r_cy    <= 8'd0;
                        r_state <= ST_DRAW;
                     end else begin
                        r_cy <= r_cy + 8'd1;
                     end
                  end else begin
                     r_cx <= r_cx + 8'd1;
                  end
               end
               ST_DRAW: begin
                  if (|w_gnt) begin
                     // Off-screen requests are consumed but never written
                     r_wr_en <= w_in_range;
                     r_x     <= w_sel_x;
                     r_y     <= w_sel_y;
                     r_color <= w_sel_color;
                     r_rr    <= w_gnt[0];
                  end
                  r_done <= r_done | done;
                  if (w_done_all) begin
                     r_state <= ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  r_state <= ST_WAIT;
               end
               default: begin
                  r_state <= ST_CLEAR;
               end
            endcase
         end
      end
   end

   assign wr_en       = r_wr_en;
   assign CounterX    = r_x;
   assign CounterY    = r_y;
   assign color       = r_color;
   assign phase       = r_state;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_fb_draw_scheduler.sv
// Directed bench for fb_draw_scheduler with W=4, H=3, a 40-cycle frame and a
// non-zero background colour. The same edge-numbered timeline holds in both
// builds: with FB_SCHED_VSYNC_EN, vsync is raised so frames start on the
// same edges (40 and 80) that the internal timebase would produce.
module tb_fb_draw_scheduler;

   localparam int          W  = 4;
   localparam int          H  = 3;
   localparam int          FC = 40;
   localparam logic [11:0] BG = 12'h3C5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [7:0]  req_x0 = 8'd0;
   logic [7:0]  req_x1 = 8'd0;
   logic [7:0]  req_y0 = 8'd0;
   logic [7:0]  req_y1 = 8'd0;
   logic [11:0] req_color0 = 12'd0;
   logic [11:0] req_color1 = 12'd0;
   logic [1:0]  done = 2'b00;
   logic [1:0]  ack;
   logic        wr_en;
   logic [7:0]  CounterX;
   logic [7:0]  CounterY;
   logic [11:0] color;
   logic [1:0]  phase;
   logic        frame_start;

   int checks = 0;
   int errors = 0;
   int e      = 0;   // rising edges since reset release

   fb_draw_scheduler #(
      .W(W), .H(H), .FRAME_CYCLES(FC), .BG_COLOR(BG)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef FB_SCHED_VSYNC_EN
      .vsync(vsync),
`endif
      .req(req),
      .req_x0(req_x0),
      .req_x1(req_x1),
      .req_y0(req_y0),
      .req_y1(req_y1),
      .req_color0(req_color0),
      .req_color1(req_color1),
      .done(done),
      .ack(ack),
      .wr_en(wr_en),
      .CounterX(CounterX),
      .CounterY(CounterY),
      .color(color),
      .phase(phase),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, e);
      end
   endtask

   // Advance one edge and settle; vsync is scheduled by edge number
   task automatic step();
      @(posedge clk);
      #1;
      e++;
`ifdef FB_SCHED_VSYNC_EN
      if (e == 37 || e == 77) vsync = 1'b1;
      else if (e == 45) vsync = 1'b0;
`endif
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_phase", phase, 0);
      check("rst_frame_start", frame_start, 0);
      check("rst_ack", ack, 0);
      check("rst_x", CounterX, 0);
      check("rst_color", color, 0);

      // Both clients request throughout CLEAR; nothing may be acked
      req_x0 = 8'd1; req_y0 = 8'd1; req_color0 = 12'hA01;
      req_x1 = 8'd2; req_y1 = 8'd2; req_color1 = 12'hB02;
      req    = 2'b11;
      @(negedge clk);
      rst_n = 1'b1;
      e     = 0;

      // CLEAR: 12 writes in raster order starting on the first edge
      for (int i = 0; i < W * H; i++) begin
         check("clear_ack", ack, 0);
         step();
         check("clear_wr_en", wr_en, 1);
         check("clear_x", CounterX, i % W);
         check("clear_y", CounterY, i / W);
         check("clear_color", color, BG);
         if (i < W * H - 1) check("clear_phase", phase, 0);
      end
      check("draw_phase", phase, 1);

      // Contention: grants alternate starting with client 0
      check("rr_ack_a", ack, 2'b01);
      step();
      check("rr_wr0_x", CounterX, 1);
      check("rr_wr0_color", color, 12'hA01);
      check("rr_ack_b", ack, 2'b10);
      step();
      check("rr_wr1_en", wr_en, 1);
      check("rr_wr1_x", CounterX, 2);
      check("rr_wr1_y", CounterY, 2);
      check("rr_wr1_color", color, 12'hB02);
      check("rr_ack_c", ack, 2'b01);
      step();
      check("rr_wr2_x", CounterX, 1);

      // Out-of-range X, then Y, then the last in-range pixel
      req = 2'b01; req_x0 = 8'd4; req_y0 = 8'd0;
      #1 check("oob_x_ack", ack, 2'b01);
      step();
      check("oob_x_wr_en", wr_en, 0);
      req_x0 = 8'd3; req_y0 = 8'd3;
      #1 check("oob_y_ack", ack, 2'b01);
      step();
      check("oob_y_wr_en", wr_en, 0);
      req_y0 = 8'd2;
      #1 check("edge_ack", ack, 2'b01);
      step();
      check("edge_wr_en", wr_en, 1);
      check("edge_x", CounterX, 3);
      check("edge_y", CounterY, 2);

      // Sole requester client 1, then contention prefers client 0 again
      req = 2'b10; req_x1 = 8'd0; req_y1 = 8'd1; req_color1 = 12'h5A5;
      #1 check("solo1_ack", ack, 2'b10);
      step();
      check("solo1_wr_en", wr_en, 1);
      check("solo1_y", CounterY, 1);
      check("solo1_color", color, 12'h5A5);
      req = 2'b11;
      #1 check("rr_after_solo", ack, 2'b01);

      // Done pulses on separate cycles -> WAIT after the second
      req  = 2'b00;
      done = 2'b01;
      #1 check("done_ack", ack, 0);
      step();
      done = 2'b00;
      check("done0_phase", phase, 1);
      check("done0_wr_en", wr_en, 0);
      step();
      check("done0_hold_phase", phase, 1);
      done = 2'b10;
      step();
      done = 2'b00;
      check("wait_phase", phase, 2);
      req = 2'b11;
      while (e < FC - 1) begin
         #1 check("wait_ack", ack, 0);
         step();
         check("wait_wr_en", wr_en, 0);
         check("wait_fs", frame_start, 0);
         check("wait_phase_hold", phase, 2);
      end
      check("wait_last_ack", ack, 0);

      // Frame start on edge 40 restarts CLEAR at (0,0)
      step();
      check("fs1_pulse", frame_start, 1);
      check("fs1_phase", phase, 0);
      check("fs1_wr_en", wr_en, 0);
      req = 2'b00;
      #1 check("fs1_clear_ack", ack, 0);
      step();
      check("fs1_pulse_end", frame_start, 0);
      check("fs1_clear_wr_en", wr_en, 1);
      check("fs1_clear_x", CounterX, 0);
      check("fs1_clear_y", CounterY, 0);
      check("fs1_clear_color", color, BG);
      while (e < FC + W * H) step();
      check("f2_draw_phase", phase, 1);

      // Done flags were cleared: one done alone must not reach WAIT
      done = 2'b01;
      step();
      done = 2'b00;
      step();
      check("f2_flags_cleared", phase, 1);

      // Request pending across the next frame start is not acked
      while (e < 2 * FC - 2) step();
      req = 2'b01; req_x0 = 8'd2; req_y0 = 8'd1; req_color0 = 12'h777;
      #1 check("pre_fs_ack", ack, 2'b01);
      step();
      check("pre_fs_wr_en", wr_en, 1);
      check("pre_fs_x", CounterX, 2);
      check("fs_cycle_ack", ack, 0);
      step();
      check("fs2_pulse", frame_start, 1);
      check("fs2_wr_en", wr_en, 0);
      check("fs2_phase", phase, 0);
      req = 2'b00;
      step();
      check("fs2_clear_wr_en", wr_en, 1);
      check("fs2_clear_x", CounterX, 0);
      check("fs2_clear_y", CounterY, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fb_draw_scheduler.md
# fb_draw_scheduler

Frame-buffer write scheduler for the 160x120, 12-bit-colour drawing path. Each frame it first clears the buffer to a background colour itself. It then shares the single frame-buffer write port between two drawing clients (e.g. the sine plotter and a second overlay engine) with round-robin arbitration. It idles until the next frame start, and its registered pixel write port feeds the frame-buffer RAM directly.

## Interface
Parameters:
- `W`, 160, frame width in pixels (≤256)
- `H`, 120, frame height in pixels (≤256)
- `FRAME_CYCLES`, 10000000, clk cycles per frame (internal timebase); must exceed W*H
- `BG_COLOR`, 12'h000, clear colour

Ports:
- `clk`  in  1  single system clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `vsync`  in  1  frame-start reference (present only with `FB_SCHED_VSYNC_EN`)
- `req[1:0]`  in  2  client write request, one bit per client
- `req_x0`, `req_x1`  in  8  client X coordinate
- `req_y0`, `req_y1`  in  8  client Y coordinate
- `req_color0`, `req_color1`  in  12  client pixel colour
- `done[1:0]`  in  2  client finished drawing this frame (pulse or level)
- `ack[1:0]`  out  2  combinational grant; request consumed this cycle
- `wr_en`  out  1  registered frame-buffer write strobe
- `CounterX`  out  8  registered write X
- `CounterY`  out  8  registered write Y
- `color`  out  12  registered write colour
- `phase`  out  2  00 CLEAR, 01 DRAW, 10 WAIT
- `frame_start`  out  1  one-cycle pulse when a frame begins

## Operation
- Reset: state CLEAR, clear X/Y = 0, frame counter = 0, RR pointer = client 0, done flags = 0. All outputs are 0 except `phase` = 00.
- CLEAR:
  - One write per cycle at (cx, cy, `BG_COLOR`).
  - cx increments and wraps at W-1 to 0, at which point cy increments.
  - The write at (W-1, H-1) is the last; the next state is DRAW. CLEAR lasts exactly W*H cycles.
  - `ack` = 0 throughout CLEAR.
- DRAW:
  - At most one grant per cycle.
  - If only one client requests, it is granted.
  - If both request, the grant goes to the client not granted last; the pointer updates on every grant.
  - The granted client's x/y/colour are registered to the write port.
  - If x ≥ W or y ≥ H, the request is still acked but `wr_en` stays 0 for that write.
- Done flags: sticky per client, set from `done` during DRAW and cleared at frame start. When both flags are set (including by a `done` arriving in the same cycle), the next state is WAIT.
- WAIT: no writes, `ack` = 0.
- Frame start (internal counter reaches FRAME_CYCLES-1, or vsync edge):
  - Pulses `frame_start`.
  - Counter returns to 0, cx/cy return to 0, done flags clear, and the state becomes CLEAR.
  - Frame start takes effect from any state, including mid-CLEAR and mid-DRAW. Any request that would be granted in that cycle is not acked.
- Frame start overrides a simultaneous DRAW→WAIT transition.

## Timing
- `ack` is combinational in the same cycle as `req`.
- `wr_en`/`CounterX`/`CounterY`/`color` are valid on the cycle after the ack or clear step (latency 1).
- The `phase` output changes on the clock edge on which the state register updates.
- The first CLEAR write appears 1 cycle after reset release or after `frame_start`.
- A client holds req/x/y/colour stable until acked; dropping `req` before ack is legal and causes no write.
- The async reset takes effect immediately mid-operation; the block restarts at CLEAR (0,0) on the first edge after release.

## Configuration
- `FB_SCHED_VSYNC_EN` defined:
  - Adds the `vsync` port, synchronised through 2 flops.
  - A frame starts on the synchronised rising edge; `frame_start` pulses 3 cycles after the vsync rise.
  - The internal frame counter and `FRAME_CYCLES` are unused.
- Not defined:
  - No `vsync` port.
  - A frame starts every `FRAME_CYCLES` cycles from the internal counter; the first frame starts at reset release.

## Test plan
- Reset release, W=4, H=3 -> 12 consecutive `wr_en` cycles at (0,0),(1,0)…(3,2), colour BG_COLOR; then `phase`=01.
- In DRAW, both `req` held continuously -> `ack` alternates 01,10,01…; each write carries the acked client's coordinates one cycle later.
- Client 0 requests (200,5) with W=160 -> `ack[0]`=1 and `wr_en` stays 0 the next cycle.
- `done[0]` then `done[1]` pulsed on separate cycles -> `phase`=10 the cycle after the second; no acks until the next `frame_start`.
- FRAME_CYCLES=20, W=4, H=3, both clients never done -> `frame_start` every 20 cycles; CLEAR restarts at (0,0) with done flags zeroed.
- `FB_SCHED_VSYNC_EN`: vsync rises mid-DRAW -> `frame_start` 3 cycles later, requests unacked in that cycle, CLEAR restarts.
